// File: rtl/connect4_pkg.sv
// Shared codes and constants for the Connect4 turn controller and its win detector.
// Board bit r*4+c: row 0 is the bottom row, column 0 is bit 0 of each row nibble.
package connect4_pkg;

    localparam int BOARD_CELLS = 16;
    localparam int NUM_LINES   = 10;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_P1   = 2'b01;
    localparam logic [1:0] ST_P2   = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Four rows, four columns, main diagonal, anti-diagonal.
    localparam logic [NUM_LINES-1:0][BOARD_CELLS-1:0] LINE_MASKS = {
        16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
        16'h1111, 16'h2222, 16'h4444, 16'h8888,
        16'h8421, 16'h1248
    };

    typedef enum logic [2:0] {
        S_WAIT,
        S_LATCH,
        S_DROP,
        S_SETTLE,
        S_EVAL,
        S_OVER
    } fsm_t;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/connect4_win_detect.sv
// Combinational line check: flags a win when any of the ten 4-cell lines
// is fully covered by the given player's occupancy mask.
module connect4_win_detect
    import connect4_pkg::*;
(
    input  logic [BOARD_CELLS-1:0] player_mask,
    output logic                   win
);

    always_comb begin
        win = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if ((player_mask & LINE_MASKS[i]) == LINE_MASKS[i]) begin
                win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/connect4_turn_controller.sv
// Turn sequencer for the 4x4 Connect4 column datapath: request sync/edge detect,
// column latch and check, one-cycle drop code, win/draw evaluation, turn timer.
module connect4_turn_controller
    import connect4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   move_req,
    input  logic [3:0]             in_column,
    input  logic                   invalid_column,
    input  logic [BOARD_CELLS-1:0] out_gameboard,
    input  logic [BOARD_CELLS-1:0] out_players_cells,
    output logic [1:0]             state,
    output logic [3:0]             column_sel,
    output logic                   current_player,
    output logic                   move_error,
    output logic [1:0]             winner,
    output logic                   draw,
    output logic                   game_over
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);

    logic [1:0]    rst_sync;
    logic          rst_n_int;
    logic [SS-1:0] req_sync_p0;
    logic          req_prev_p1;
    logic          req_rise;
    logic [TW-1:0] timer;
    logic          timer_expire;
    fsm_t          fsm_state, fsm_next;
    logic          latch_en, err_set, toggle, reload, win_set, draw_set;
    logic [BOARD_CELLS-1:0] player_mask;
    logic          player_win;

    // Asserts immediately with reset, releases two clocks after it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    // --- stage: move_req synchronizer and rising-edge detect ---
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            req_sync_p0 <= '0;
            req_prev_p1 <= 1'b0;
        end else begin
            req_sync_p0 <= {req_sync_p0[SS-2:0], move_req};
            req_prev_p1 <= req_sync_p0[SS-1];
        end
    end
    assign req_rise = req_sync_p0[SS-1] & ~req_prev_p1;

    assign timer_expire = (TIMEOUT_CYCLES > 0) && (fsm_state == S_WAIT) && (timer == TW'(1));

    assign player_mask = current_player ? (out_gameboard & out_players_cells)
                                        : (out_gameboard & ~out_players_cells);

    connect4_win_detect u_win_detect (
        .player_mask (player_mask),
        .win         (player_win)
    );

    // --- stage: turn FSM ---
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) fsm_state <= S_WAIT;
        else            fsm_state <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm_state;
        latch_en = 1'b0;
        err_set  = 1'b0;
        toggle   = 1'b0;
        reload   = 1'b0;
        win_set  = 1'b0;
        draw_set = 1'b0;
        case (fsm_state)
            S_WAIT: begin
                if (req_rise) begin
                    fsm_next = S_LATCH;
                end else if (timer_expire) begin
                    toggle  = 1'b1;
                    reload  = 1'b1;
                    err_set = 1'b1;
                end
            end
            S_LATCH: begin
                latch_en = 1'b1;
                if (is_one_hot(in_column)) begin
                    fsm_next = S_DROP;
                end else begin
                    err_set  = 1'b1;
                    fsm_next = S_WAIT;
                end
            end
            S_DROP:   fsm_next = S_SETTLE;
            S_SETTLE: fsm_next = S_EVAL;
            S_EVAL: begin
                // A full column outranks any line the stale board might show.
                if (invalid_column) begin
                    err_set  = 1'b1;
                    fsm_next = S_WAIT;
                end else if (player_win) begin
                    win_set  = 1'b1;
                    fsm_next = S_OVER;
                end else if (out_gameboard == '1) begin
                    draw_set = 1'b1;
                    fsm_next = S_OVER;
                end else begin
                    toggle   = 1'b1;
                    reload   = 1'b1;
                    fsm_next = S_WAIT;
                end
            end
            S_OVER:  fsm_next = S_OVER;
            default: fsm_next = S_WAIT;
        endcase
    end

    // --- stage: registered turn state and results ---
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            column_sel     <= 4'b0000;
            current_player <= 1'b0;
            move_error     <= 1'b0;
            winner         <= WIN_NONE;
            draw           <= 1'b0;
            timer          <= TIMER_LOAD;
        end else begin
            move_error <= err_set;
            if (latch_en) column_sel <= in_column;
            if (toggle)   current_player <= ~current_player;
            if (win_set)  winner <= current_player ? WIN_P2 : WIN_P1;
            if (draw_set) draw <= 1'b1;
            if (reload)
                timer <= TIMER_LOAD;
            else if (fsm_state == S_WAIT && timer != '0)
                timer <= timer - TW'(1);
        end
    end

    assign state     = (fsm_state == S_DROP) ? (current_player ? ST_P2 : ST_P1) : ST_IDLE;
    assign game_over = (fsm_state == S_OVER);

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Directed bench for connect4_turn_controller; the bench plays the datapath role by
// updating board/cell inputs itself when it observes a drop code.
module tb_connect4_turn_controller;
    import connect4_pkg::*;

    logic        clk;
    logic        reset, reset_t;
    logic        move_req, move_req_t;
    logic [3:0]  in_column;
    logic        invalid_column;
    logic [15:0] out_gameboard, out_players_cells;

    logic [1:0]  state, state_t;
    logic [3:0]  column_sel, column_sel_t;
    logic        current_player, current_player_t;
    logic        move_error, move_error_t;
    logic [1:0]  winner, winner_t;
    logic        draw, draw_t;
    logic        game_over, game_over_t;

    int checks   = 0;
    int failures = 0;

    connect4_turn_controller dut (
        .clk(clk), .reset(reset), .move_req(move_req), .in_column(in_column),
        .invalid_column(invalid_column), .out_gameboard(out_gameboard),
        .out_players_cells(out_players_cells), .state(state), .column_sel(column_sel),
        .current_player(current_player), .move_error(move_error), .winner(winner),
        .draw(draw), .game_over(game_over)
    );

    connect4_turn_controller #(.TIMEOUT_CYCLES(20), .SYNC_STAGES(2)) dut_t (
        .clk(clk), .reset(reset_t), .move_req(move_req_t), .in_column(in_column),
        .invalid_column(invalid_column), .out_gameboard(out_gameboard),
        .out_players_cells(out_players_cells), .state(state_t), .column_sel(column_sel_t),
        .current_player(current_player_t), .move_error(move_error_t), .winner(winner_t),
        .draw(draw_t), .game_over(game_over_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        move_req = 1'b0;
        in_column = 4'b0000;
        invalid_column = 1'b0;
        out_gameboard = 16'h0000;
        out_players_cells = 16'h0000;
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
    endtask

    // code_exp = ST_IDLE means the request must be rejected in LATCH.
    task automatic play(input string tag, input logic [3:0] col, input logic [1:0] code_exp,
                        input logic err_exp, input logic player_exp);
        int c;
        int row;
        in_column = col;
        move_req  = 1'b1;
        repeat (3) step();
        check_eq({tag, "_latch_state"}, 16'(state), 16'(ST_IDLE));
        step();
        check_eq({tag, "_drop_code"}, 16'(state), 16'(code_exp));
        check_eq({tag, "_column_sel"}, 16'(column_sel), 16'(col));
        if (code_exp != ST_IDLE) begin
            c = 0;
            for (int i = 0; i < 4; i++) if (col[i]) c = i;
            row = -1;
            for (int r = 3; r >= 0; r--) if (!out_gameboard[r*4+c]) row = r;
            if (row < 0) begin
                invalid_column = 1'b1;
            end else begin
                out_gameboard[row*4+c]     = 1'b1;
                out_players_cells[row*4+c] = (code_exp == ST_P2);
            end
            step();
            check_eq({tag, "_settle_state"}, 16'(state), 16'(ST_IDLE));
            step();
            check_eq({tag, "_eval_column_sel"}, 16'(column_sel), 16'(col));
            step();
        end
        check_eq({tag, "_move_error"}, 16'(move_error), 16'(err_exp));
        check_eq({tag, "_player"}, 16'(current_player), 16'(player_exp));
        step();
        check_eq({tag, "_move_error_width"}, 16'(move_error), 16'h0);
        move_req = 1'b0;
        invalid_column = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int gap;
        int seen_drop;
        int found;

        reset_t = 1'b0;
        move_req_t = 1'b0;
        do_reset();

        check_eq("rst_state", 16'(state), 16'(ST_IDLE));
        check_eq("rst_column_sel", 16'(column_sel), 16'h0);
        check_eq("rst_player", 16'(current_player), 16'h0);
        check_eq("rst_move_error", 16'(move_error), 16'h0);
        check_eq("rst_winner", 16'(winner), 16'(WIN_NONE));
        check_eq("rst_draw", 16'(draw), 16'h0);
        check_eq("rst_game_over", 16'(game_over), 16'h0);

        // First move, two rejected requests, then fill column 0 and overflow it.
        play("p1_c0",    4'b0001, ST_P1,   1'b0, 1'b1);
        play("rej_0110", 4'b0110, ST_IDLE, 1'b1, 1'b1);
        play("rej_0000", 4'b0000, ST_IDLE, 1'b1, 1'b1);
        play("p2_c0",    4'b0001, ST_P2,   1'b0, 1'b0);
        play("p1_c0b",   4'b0001, ST_P1,   1'b0, 1'b1);
        play("p2_c0c",   4'b0001, ST_P2,   1'b0, 1'b0);
        play("full_c0",  4'b0001, ST_P1,   1'b1, 1'b0);
        play("retry_c1", 4'b0010, ST_P1,   1'b0, 1'b1);
        check_eq("mid_game_over", 16'(game_over), 16'h0);

        // P1 completes the bottom row.
        do_reset();
        play("w1", 4'b0001, ST_P1, 1'b0, 1'b1);
        play("w2", 4'b0001, ST_P2, 1'b0, 1'b0);
        play("w3", 4'b0010, ST_P1, 1'b0, 1'b1);
        play("w4", 4'b0010, ST_P2, 1'b0, 1'b0);
        play("w5", 4'b0100, ST_P1, 1'b0, 1'b1);
        play("w6", 4'b0100, ST_P2, 1'b0, 1'b0);
        play("w7", 4'b1000, ST_P1, 1'b0, 1'b0);
        check_eq("win_winner", 16'(winner), 16'(WIN_P1));
        check_eq("win_game_over", 16'(game_over), 16'h1);
        check_eq("win_draw", 16'(draw), 16'h0);

        in_column = 4'b0001;
        move_req  = 1'b1;
        seen_drop = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (state != ST_IDLE || move_error) seen_drop = 1;
        end
        move_req = 1'b0;
        check_eq("over_ignores_req", 16'(seen_drop), 16'h0);
        check_eq("over_winner_held", 16'(winner), 16'(WIN_P1));
        check_eq("over_game_over_held", 16'(game_over), 16'h1);

        // Last empty cell filled with no line for either player.
        do_reset();
        out_gameboard     = 16'h7FFF;
        out_players_cells = 16'h3C3C;
        play("draw_move", 4'b1000, ST_P1, 1'b0, 1'b0);
        check_eq("draw_flag", 16'(draw), 16'h1);
        check_eq("draw_winner", 16'(winner), 16'(WIN_NONE));
        check_eq("draw_game_over", 16'(game_over), 16'h1);

        // Reset asserted while the second move sits in SETTLE.
        do_reset();
        play("pre_rst", 4'b0100, ST_P1, 1'b0, 1'b1);
        in_column = 4'b1000;
        move_req  = 1'b1;
        repeat (4) step();
        check_eq("midrst_drop", 16'(state), 16'(ST_P2));
        step();
        check_eq("midrst_col_before", 16'(column_sel), 16'h8);
        reset = 1'b0;
        #1;
        check_eq("midrst_state", 16'(state), 16'(ST_IDLE));
        check_eq("midrst_column_sel", 16'(column_sel), 16'h0);
        check_eq("midrst_player", 16'(current_player), 16'h0);
        check_eq("midrst_move_error", 16'(move_error), 16'h0);
        check_eq("midrst_game_over", 16'(game_over), 16'h0);
        move_req = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();

        // Turn timer on the second instance: forfeits every 20 idle cycles.
        reset_t = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            step();
            if (move_error_t) found = 1;
        end
        check_eq("tmo_first_pulse", 16'(found), 16'h1);
        check_eq("tmo_player_toggled", 16'(current_player_t), 16'h1);
        check_eq("tmo_state_idle", 16'(state_t), 16'(ST_IDLE));
        step();
        check_eq("tmo_pulse_width", 16'(move_error_t), 16'h0);
        gap = 1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            gap++;
            if (move_error_t) found = 1;
        end
        check_eq("tmo_second_pulse", 16'(found), 16'h1);
        check_eq("tmo_period", 16'(gap), 16'd20);
        check_eq("tmo_player_back", 16'(current_player_t), 16'h0);
        check_eq("tmo_no_result", 16'({winner_t, draw_t, game_over_t, column_sel_t}), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
